game_master_fsm: RTL
====================

Name: game_master_fsm

Overview:
- Top-level game-flow controller for the snake game; the parametrised successor to the three-state start/play/finish master.
- Adds pause, lose, multi-level progression with a timed level-up interlude, restart from end states, and an on-chip score/level counter.
- Sits between the button inputs and the snake engine, display and score blocks; downstream blocks gate on STATE and GAME_ACTIVE.

Parameters:
- SCORE_W, 8, width of cumulative SCORE counter.
- TARGET_SCORE, 10, SCORE_INC pulses needed to clear one level (≥1).
- NUM_LEVELS, 4, number of levels (≥1). Clearing the last level wins.
- LEVEL_UP_CYCLES, 50000000, duration of the LEVEL_UP interlude in CLK cycles (≥1).
- LVL_W, derived localparam: max(1, clog2(NUM_LEVELS)).

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- BTN_U, BTN_D, BTN_L, BTN_R  in  1 each  direction buttons, level-sensitive, already debounced.
- BTN_C  in  1  centre button (pause/resume/restart), debounced; the block uses its rising edge.
- SCORE_INC  in  1  one-cycle pulse: snake ate food.
- COLLISION  in  1  one-cycle pulse: snake hit wall or self.
- STATE  out  3  IDLE=000, PLAY=001, WIN=010, LOSE=011, PAUSE=100, LEVEL_UP=101.
- SCORE  out  SCORE_W  cumulative score.
- LEVEL  out  LVL_W  current level, 0-based.
- GAME_ACTIVE  out  1  high only when STATE==PLAY.

Behaviour:
- Reset (RESET low, asynchronous): STATE=IDLE, SCORE=0, LEVEL=0, internal level-progress counter=0, interlude timer=0, GAME_ACTIVE=0. The BTN_C previous-value register resets to 1, so a button held through reset produces no edge.
- c_edge = BTN_C & ~prev_C, with prev_C registered every cycle. All outputs are registered; GAME_ACTIVE decodes the registered state only.
- IDLE:
  - Any direction button high moves to PLAY next cycle.
  - SCORE, LEVEL and the progress counter are held at 0.
  - BTN_C, SCORE_INC and COLLISION are ignored.
- PLAY, priority COLLISION > SCORE_INC > c_edge:
  - COLLISION: go to LOSE. A SCORE_INC in the same cycle is discarded.
  - SCORE_INC: SCORE+1, saturating at 2^SCORE_W-1. Progress+1.
    - If progress+1 == TARGET_SCORE: progress<=0.
    - If LEVEL == NUM_LEVELS-1, go to WIN.
    - Otherwise go to LEVEL_UP, with LEVEL+1 and timer<=0 in the same edge.
  - c_edge alone: go to PAUSE. A c_edge coinciding with SCORE_INC is dropped.
- PAUSE:
  - c_edge returns to PLAY.
  - SCORE_INC and COLLISION are ignored; SCORE, LEVEL and progress are frozen.
- LEVEL_UP:
  - Timer increments each cycle. When timer == LEVEL_UP_CYCLES-1, go to PLAY; dwell is exactly LEVEL_UP_CYCLES cycles.
  - All game inputs and c_edge are ignored.
- WIN, LOSE:
  - SCORE and LEVEL are held for display.
  - c_edge goes to IDLE and clears SCORE, LEVEL and progress in the same edge.
  - Direction buttons are ignored.
- Unused encodings (110, 111) go to IDLE next cycle with counters cleared.
- Reset asserted in any state, mid-interlude included, forces the reset values immediately. Operation resumes on the first rising CLK edge after RESET goes high.

Test Plan (TARGET_SCORE=3, NUM_LEVELS=2, LEVEL_UP_CYCLES=4, SCORE_W=4):
- Reset and start: hold BTN_C high through reset release, then pulse BTN_L. Expect STATE 000 with no PAUSE entry, then 001 one cycle after BTN_L; GAME_ACTIVE=1.
- Level progression: 3 SCORE_INC pulses. Expect SCORE=3, LEVEL=1, STATE=101 for exactly 4 cycles, then 001. 3 more pulses give SCORE=6 and STATE=010.
- Collision priority: in PLAY with SCORE=2, assert COLLISION and SCORE_INC in the same cycle. Expect STATE=011 and SCORE stays 2. A BTN_C edge then gives STATE=000, SCORE=0, LEVEL=0.
- Pause: in PLAY, BTN_C edge gives STATE=100. SCORE_INC and COLLISION pulses leave SCORE and STATE unchanged. A second edge returns STATE=001. Holding BTN_C high across cycles produces only one transition.
- Saturation: SCORE_W=2, TARGET_SCORE=10, 5 SCORE_INC pulses. Expect SCORE to stop at 3 while the level is not yet cleared.
- Async reset mid-LEVEL_UP: drop RESET at interlude cycle 2 between clock edges. Outputs return to IDLE/0 immediately, without waiting for a CLK edge.

Source files
------------

// File: rtl/game_master_fsm.sv
// game_master_fsm: snake game flow controller with pause, win/lose, timed level-up interlude and score/level counters.
module game_master_fsm #(
    parameter int SCORE_W         = 8,
    parameter int TARGET_SCORE    = 10,
    parameter int NUM_LEVELS      = 4,
    parameter int LEVEL_UP_CYCLES = 50000000,
    localparam int LVL_W          = (NUM_LEVELS > 2) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               BTN_U,
    input  logic               BTN_D,
    input  logic               BTN_L,
    input  logic               BTN_R,
    input  logic               BTN_C,
    input  logic               SCORE_INC,
    input  logic               COLLISION,
    output logic [2:0]         STATE,
    output logic [SCORE_W-1:0] SCORE,
    output logic [LVL_W-1:0]   LEVEL,
    output logic               GAME_ACTIVE
);
    localparam int PRG_W = (TARGET_SCORE > 2) ? $clog2(TARGET_SCORE) : 1;
    localparam int TMR_W = (LEVEL_UP_CYCLES > 2) ? $clog2(LEVEL_UP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        PLAY     = 3'b001,
        WIN      = 3'b010,
        LOSE     = 3'b011,
        PAUSE    = 3'b100,
        LEVEL_UP = 3'b101
    } state_t;

    state_t             state;
    logic [PRG_W-1:0]   prog;
    logic [TMR_W-1:0]   timer;
    logic               prev_c;
    logic               c_edge;

    assign c_edge      = BTN_C & ~prev_c;
    assign STATE       = state;
    assign GAME_ACTIVE = (state == PLAY);

    // prev_c resets high so a centre button held through reset yields no edge
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state  <= IDLE;
            SCORE  <= '0;
            LEVEL  <= '0;
            prog   <= '0;
            timer  <= '0;
            prev_c <= 1'b1;
        end else begin
            prev_c <= BTN_C;
            case (state)
                IDLE: begin
                    SCORE <= '0;
                    LEVEL <= '0;
                    prog  <= '0;
                    if (BTN_U | BTN_D | BTN_L | BTN_R) state <= PLAY;
                end
                PLAY: begin
                    if (COLLISION) begin
                        state <= LOSE;
                    end else if (SCORE_INC) begin
                        SCORE <= (SCORE == '1) ? SCORE : SCORE + 1'b1;
                        if (prog == PRG_W'(TARGET_SCORE - 1)) begin
                            prog <= '0;
                            if (LEVEL == LVL_W'(NUM_LEVELS - 1)) begin
                                state <= WIN;
                            end else begin
                                state <= LEVEL_UP;
                                LEVEL <= LEVEL + 1'b1;
                                timer <= '0;
                            end
                        end else begin
                            prog <= prog + 1'b1;
                        end
                    end else if (c_edge) begin
                        state <= PAUSE;
                    end
                end
                PAUSE: if (c_edge) state <= PLAY;
                LEVEL_UP: begin
                    timer <= timer + 1'b1;
                    if (timer == TMR_W'(LEVEL_UP_CYCLES - 1)) state <= PLAY;
                end
                WIN, LOSE: begin
                    if (c_edge) begin
                        state <= IDLE;
                        SCORE <= '0;
                        LEVEL <= '0;
                        prog  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    SCORE <= '0;
                    LEVEL <= '0;
                    prog  <= '0;
                    timer <= '0;
                end
            endcase
        end
    end
endmodule
